// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory path: bus width, lane count and
// access-size encodings used by both the LSU and dmem_ctrl.
package dmem_ctrl_pkg;

    localparam int XLEN  = 64;
    localparam int LANES = XLEN / 8;

    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        HALF   = 2'd1,
        WORD   = 2'd2,
        DOUBLE = 2'd3
    } size_e;

    // Unshifted byte-select pattern for an access of the given size.
    function automatic logic [LANES-1:0] size_to_sel(input size_e size);
        logic [LANES-1:0] sel;
        case (size)
            BYTE:    sel = 8'h01;
            HALF:    sel = 8'h03;
            WORD:    sel = 8'h0F;
            default: sel = 8'hFF;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// c2c_data bus: one request at a time, requester holds it stable until ack.
interface c2c_data #(
    parameter int ADDR_W = 32
);
    import dmem_ctrl_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic [LANES-1:0]  sel;
    logic              re;
    logic              we;
    logic [XLEN-1:0]   data_w;
    logic [XLEN-1:0]   data_r;
    logic              ack;

    modport master (output addr, sel, re, we, data_w, input data_r, ack);
    modport slave  (input addr, sel, re, we, data_w, output data_r, ack);

endinterface

// File: rtl/dmem_ctrl_lane_align.sv
// dmem_lane_align: purely combinational byte-lane steering between the bus
// and a 64-bit memory. Left-shifts select and write data into a 16-lane
// window, and right-shifts a 128-bit read window back down to bus lanes.
module dmem_lane_align
    import dmem_ctrl_pkg::*;
(
    input  logic [2:0]         off,
    input  logic [LANES-1:0]   sel,
    input  logic [XLEN-1:0]    wdata,
    input  logic [XLEN-1:0]    rd_lo,
    input  logic [XLEN-1:0]    rd_hi,
    output logic [2*LANES-1:0] sel16,
    output logic [2*XLEN-1:0]  wd128,
    output logic [XLEN-1:0]    rd_out
);

    logic [2*XLEN-1:0] rd128;
    assign rd128 = {rd_hi, rd_lo};

    genvar gi;

    // Output lane gi of the shifted window takes source lane gi-off when that
    // lies inside the 8 bus lanes; negative differences wrap to >= 8.
    generate
        for (gi = 0; gi < 2*LANES; gi++) begin : g_wr_lane
            logic [4:0] src;
            logic       in_range;
            assign src      = 5'(gi) - {2'b00, off};
            assign in_range = (src < 5'(LANES));
            assign sel16[gi]          = in_range ? sel[src[2:0]] : 1'b0;
            assign wd128[8*gi +: 8]   = in_range ? wdata[{src[2:0], 3'b000} +: 8] : 8'h00;
        end
    endgenerate

    // Bus lane gi reads window lane gi+off.
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_rd_lane
            logic [3:0] idx;
            assign idx                = 4'(gi) + {1'b0, off};
            assign rd_out[8*gi +: 8]  = rd128[{idx, 3'b000} +: 8];
        end
    endgenerate

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: c2c_data slave driving a 64-bit single-port SRAM with byte
// enables. Accesses crossing a 64-bit boundary take two SRAM beats.
// Optional build macro DMEM_MISALIGN_FAULT_EN: crossing accesses are not
// serviced; they are acked with a fault pulse instead.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    c2c_data.slave                data_bus,
    output logic                  mem_en,
    output logic [LANES-1:0]      mem_we,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic [XLEN-1:0]       mem_wdata,
    input  logic [XLEN-1:0]       mem_rdata
`ifdef DMEM_MISALIGN_FAULT_EN
    ,
    output logic                  fault
`endif
);

    typedef enum logic [1:0] {IDLE, BEAT1, DONE, ACKW} state_e;

    state_e state_reg, state_next;
    logic [XLEN-1:0] lo_reg, lo_next;
    logic [XLEN-1:0] data_r_reg, data_r_next;
    logic            split_reg, split_next;
    logic            rd_reg, rd_next;

    logic [2:0]            off;
    logic [DEPTH_LOG2-1:0] word;
    logic                  req;
    logic                  split;
    logic                  issue;
    logic                  ack;
    logic [2*LANES-1:0]    sel16;
    logic [2*XLEN-1:0]     wd128;
    logic [XLEN-1:0]       rd_lo, rd_hi, rd_aligned;

    assign off  = data_bus.addr[2:0];
    assign word = data_bus.addr[DEPTH_LOG2+2:3];
    assign req  = data_bus.re | data_bus.we;

    // Bus address bits above the SRAM word index are deliberately ignored.
    generate
        if (ADDR_W > DEPTH_LOG2 + 3) begin : g_unused_addr
            logic unused_addr_bits;
            assign unused_addr_bits = ^data_bus.addr[ADDR_W-1:DEPTH_LOG2+3];
        end
    endgenerate

    // Unsplit reads align the current SRAM word alone; split reads join the
    // captured low word with the word arriving now.
    assign rd_lo = split_reg ? lo_reg    : mem_rdata;
    assign rd_hi = split_reg ? mem_rdata : '0;

    dmem_lane_align u_align (
        .off    (off),
        .sel    (data_bus.sel),
        .wdata  (data_bus.data_w),
        .rd_lo  (rd_lo),
        .rd_hi  (rd_hi),
        .sel16  (sel16),
        .wd128  (wd128),
        .rd_out (rd_aligned)
    );

    assign split = |sel16[2*LANES-1:LANES];

    // Next-state and SRAM/bus output decode; reset forces everything idle.
    always_comb begin
        state_next  = state_reg;
        lo_next     = lo_reg;
        data_r_next = data_r_reg;
        split_next  = split_reg;
        rd_next     = rd_reg;
        issue       = 1'b0;
        mem_en      = 1'b0;
        mem_we      = '0;
        mem_addr    = '0;
        mem_wdata   = '0;
        ack         = 1'b0;
`ifdef DMEM_MISALIGN_FAULT_EN
        fault       = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (req) begin
                    split_next = split;
                    rd_next    = data_bus.re;
`ifdef DMEM_MISALIGN_FAULT_EN
                    issue      = !split;
                    state_next = DONE;
`else
                    issue      = 1'b1;
                    state_next = split ? BEAT1 : DONE;
`endif
                    if (issue) begin
                        mem_en    = 1'b1;
                        mem_addr  = word;
                        mem_we    = data_bus.re ? '0 : sel16[LANES-1:0];
                        mem_wdata = wd128[XLEN-1:0];
                    end
                end
            end
            BEAT1: begin
                if (rd_reg) begin
                    lo_next = mem_rdata;
                end
                mem_en     = 1'b1;
                mem_addr   = word + 1'b1;
                mem_we     = rd_reg ? '0 : sel16[2*LANES-1:LANES];
                mem_wdata  = wd128[2*XLEN-1:XLEN];
                state_next = DONE;
            end
            DONE: begin
                ack        = 1'b1;
                state_next = ACKW;
`ifdef DMEM_MISALIGN_FAULT_EN
                if (split_reg) begin
                    fault       = 1'b1;
                    data_r_next = '0;
                end else
`endif
                if (rd_reg) begin
                    data_r_next = rd_aligned;
                end
            end
            ACKW: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (!rst_n) begin
            state_next  = IDLE;
            lo_next     = '0;
            data_r_next = '0;
            split_next  = 1'b0;
            rd_next     = 1'b0;
            mem_en      = 1'b0;
            mem_we      = '0;
            mem_addr    = '0;
            mem_wdata   = '0;
            ack         = 1'b0;
`ifdef DMEM_MISALIGN_FAULT_EN
            fault       = 1'b0;
`endif
        end
    end

    // data_r is live during DONE and holds the registered copy otherwise.
    assign data_bus.data_r = data_r_next;
    assign data_bus.ack    = ack;

    // State and holding registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            lo_reg     <= '0;
            data_r_reg <= '0;
            split_reg  <= 1'b0;
            rd_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            lo_reg     <= lo_next;
            data_r_reg <= data_r_next;
            split_reg  <= split_next;
            rd_reg     <= rd_next;
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed testbench for dmem_ctrl: unit a uses the default 4096-word SRAM,
// unit b a 4-word SRAM for the wrap-around case. Each DUT has its own SRAM model.
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    c2c_data #(.ADDR_W(32)) bus_a ();
    c2c_data #(.ADDR_W(32)) bus_b ();

    logic        a_en,  b_en;
    logic [7:0]  a_we,  b_we;
    logic [11:0] a_addr;
    logic [1:0]  b_addr;
    logic [63:0] a_wdata, b_wdata, a_rdata, b_rdata;
`ifdef DMEM_MISALIGN_FAULT_EN
    logic        a_fault, b_fault;
`endif

    dmem_ctrl #(.ADDR_W(32), .DEPTH_LOG2(12)) dut_a (
        .clk(clk), .rst_n(rst_n), .data_bus(bus_a.slave),
        .mem_en(a_en), .mem_we(a_we), .mem_addr(a_addr),
        .mem_wdata(a_wdata), .mem_rdata(a_rdata)
`ifdef DMEM_MISALIGN_FAULT_EN
        , .fault(a_fault)
`endif
    );

    dmem_ctrl #(.ADDR_W(32), .DEPTH_LOG2(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .data_bus(bus_b.slave),
        .mem_en(b_en), .mem_we(b_we), .mem_addr(b_addr),
        .mem_wdata(b_wdata), .mem_rdata(b_rdata)
`ifdef DMEM_MISALIGN_FAULT_EN
        , .fault(b_fault)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM models with a bench-side preload port.
    logic [63:0] mem_a [0:4095];
    logic [63:0] mem_b [0:3];
    logic        pl_en;
    logic        pl_unit;
    logic [11:0] pl_addr;
    logic [63:0] pl_data;

    always @(posedge clk) begin
        if (pl_en && !pl_unit) mem_a[pl_addr] <= pl_data;
        else if (a_en) begin
            for (int i = 0; i < 8; i++)
                if (a_we[i]) mem_a[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
            a_rdata <= mem_a[a_addr];
        end
    end

    always @(posedge clk) begin
        if (pl_en && pl_unit) mem_b[pl_addr[1:0]] <= pl_data;
        else if (b_en) begin
            for (int i = 0; i < 8; i++)
                if (b_we[i]) mem_b[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
            b_rdata <= mem_b[b_addr];
        end
    end

    // Observations from the most recent transaction window.
    int          obs_ack_cnt, obs_en_cnt, obs_fault_cnt;
    int          obs_ack_cyc [4];
    logic [11:0] obs_addr [4];
    logic [7:0]  obs_we [4];
    logic [63:0] obs_wd [4];
    logic [7:0]  obs_we_or;
    logic [63:0] obs_data, obs_data_end;
    logic        obs_fault_at_ack;

    logic        s_en, s_ack, s_fault;
    logic [7:0]  s_we;
    logic [11:0] s_addr;
    logic [63:0] s_wd, s_data;

    task automatic drive(input int unit, input logic r, input logic w, input logic [31:0] a,
                         input logic [7:0] s, input logic [63:0] d);
        if (unit == 0) begin
            bus_a.re = r; bus_a.we = w; bus_a.addr = a; bus_a.sel = s; bus_a.data_w = d;
        end else begin
            bus_b.re = r; bus_b.we = w; bus_b.addr = a; bus_b.sel = s; bus_b.data_w = d;
        end
    endtask

    task automatic sample(input int unit);
        if (unit == 0) begin
            s_en = a_en; s_we = a_we; s_addr = a_addr; s_wd = a_wdata;
            s_ack = bus_a.ack; s_data = bus_a.data_r;
`ifdef DMEM_MISALIGN_FAULT_EN
            s_fault = a_fault;
`else
            s_fault = 1'b0;
`endif
        end else begin
            s_en = b_en; s_we = b_we; s_addr = {10'b0, b_addr}; s_wd = b_wdata;
            s_ack = bus_b.ack; s_data = bus_b.data_r;
`ifdef DMEM_MISALIGN_FAULT_EN
            s_fault = b_fault;
`else
            s_fault = 1'b0;
`endif
        end
    endtask

    task automatic preload(input logic unit, input logic [11:0] addr, input logic [63:0] data);
        pl_en = 1'b1; pl_unit = unit; pl_addr = addr; pl_data = data;
        @(posedge clk);
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Present one request at a negedge and watch a fixed 14-cycle window.
    // Cycle 1 is the cycle the request first appears. The request is held
    // for 'hold' further cycles after the first ack, then dropped.
    task automatic run_req(input int unit, input logic r, input logic w, input logic [31:0] a,
                           input logic [7:0] s, input logic [63:0] d, input int hold);
        int   first;
        logic dropped;
        first = 0; dropped = 1'b0;
        obs_ack_cnt = 0; obs_en_cnt = 0; obs_fault_cnt = 0; obs_we_or = 8'h00;
        obs_data = '0; obs_fault_at_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            obs_ack_cyc[i] = 0; obs_addr[i] = '0; obs_we[i] = '0; obs_wd[i] = '0;
        end
        drive(unit, r, w, a, s, d);
        for (int cyc = 1; cyc <= 14; cyc++) begin
            #1;
            sample(unit);
            if (s_en) begin
                if (obs_en_cnt < 4) begin
                    obs_addr[obs_en_cnt] = s_addr; obs_we[obs_en_cnt] = s_we; obs_wd[obs_en_cnt] = s_wd;
                end
                obs_en_cnt++;
                obs_we_or = obs_we_or | s_we;
            end
            if (s_fault) obs_fault_cnt++;
            if (s_ack) begin
                if (obs_ack_cnt < 4) obs_ack_cyc[obs_ack_cnt] = cyc;
                if (obs_ack_cnt == 0) begin
                    obs_data = s_data; obs_fault_at_ack = s_fault; first = cyc;
                end
                obs_ack_cnt++;
            end
            @(negedge clk);
            if (first != 0 && cyc >= first + hold && !dropped) begin
                drive(unit, 1'b0, 1'b0, 32'h0, 8'h00, 64'h0);
                dropped = 1'b1;
            end
        end
        drive(unit, 1'b0, 1'b0, 32'h0, 8'h00, 64'h0);
        #1;
        sample(unit);
        obs_data_end = s_data;
        $display("[TB] txn unit=%0d re=%0b we=%0b addr=%h sel=%h data_w=%h acks=%0d beats=%0d data_r=%h",
                 unit, r, w, a, s, d, obs_ack_cnt, obs_en_cnt, obs_data);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h20, 8'hFF, 64'h0);
        repeat (3) @(negedge clk);
        #1;
        n_tests++; if (bus_a.ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", bus_a.ack); end
        n_tests++; if (bus_a.data_r !== 64'h0) begin n_fail++; $display("FAIL reset_data_r: got %h expected 0", bus_a.data_r); end
        n_tests++; if (a_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en: got %b expected 0", a_en); end
        n_tests++; if (a_we !== 8'h00) begin n_fail++; $display("FAIL reset_mem_we: got %h expected 00", a_we); end
        n_tests++; if (a_addr !== 12'h000) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 000", a_addr); end
        n_tests++; if (a_wdata !== 64'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h expected 0", a_wdata); end
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 8'h00, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_aligned_read();
        run_req(0, 1'b1, 1'b0, 32'h20, 8'hFF, 64'h0, 0);
        n_tests++; if (obs_ack_cnt !== 1) begin n_fail++; $display("FAIL aligned_ack_cnt: got %0d expected 1", obs_ack_cnt); end
        n_tests++; if (obs_ack_cyc[0] !== 2) begin n_fail++; $display("FAIL aligned_ack_cycle: got %0d expected 2", obs_ack_cyc[0]); end
        n_tests++; if (obs_en_cnt !== 1 || obs_addr[0] !== 12'd4) begin n_fail++; $display("FAIL aligned_beat: got %0d beats addr %h expected 1 beat addr 004", obs_en_cnt, obs_addr[0]); end
        n_tests++; if (obs_we_or !== 8'h00) begin n_fail++; $display("FAIL aligned_mem_we: got %h expected 00", obs_we_or); end
        n_tests++; if (obs_data !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL aligned_data_r: got %h expected 0123456789abcdef", obs_data); end
        n_tests++; if (obs_data_end !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL aligned_data_r_hold: got %h expected 0123456789abcdef", obs_data_end); end
        n_tests++; if (obs_fault_cnt !== 0) begin n_fail++; $display("FAIL aligned_fault: got %0d expected 0", obs_fault_cnt); end
    endtask

    task automatic test_byte_write();
        run_req(0, 1'b0, 1'b1, 32'h13, 8'h01, 64'hAA, 0);
        n_tests++; if (obs_en_cnt !== 1 || obs_addr[0] !== 12'd2 || obs_we[0] !== 8'h08) begin n_fail++; $display("FAIL bytewr_beat: got %0d beats addr %h we %h expected 1 beat addr 002 we 08", obs_en_cnt, obs_addr[0], obs_we[0]); end
        n_tests++; if (obs_wd[0][31:24] !== 8'hAA) begin n_fail++; $display("FAIL bytewr_wdata: got %h expected lane3 aa", obs_wd[0]); end
        n_tests++; if (obs_ack_cnt !== 1 || obs_ack_cyc[0] !== 2) begin n_fail++; $display("FAIL bytewr_ack: got %0d acks at %0d expected 1 at 2", obs_ack_cnt, obs_ack_cyc[0]); end
        n_tests++; if (mem_a[2] !== 64'h11223344AA667788) begin n_fail++; $display("FAIL bytewr_mem: got %h expected 11223344aa667788", mem_a[2]); end
        run_req(0, 1'b1, 1'b0, 32'h13, 8'h01, 64'h0, 0);
        n_tests++; if (obs_data !== 64'h00000011223344AA) begin n_fail++; $display("FAIL bytewr_readback: got %h expected 00000011223344aa", obs_data); end
    endtask

    task automatic test_zero_sel();
        run_req(0, 1'b0, 1'b1, 32'h20, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        n_tests++; if (obs_ack_cnt !== 1) begin n_fail++; $display("FAIL zerosel_ack: got %0d expected 1", obs_ack_cnt); end
        n_tests++; if (obs_we_or !== 8'h00) begin n_fail++; $display("FAIL zerosel_mem_we: got %h expected 00", obs_we_or); end
        n_tests++; if (mem_a[4] !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL zerosel_mem: got %h expected 0123456789abcdef", mem_a[4]); end
    endtask

`ifndef DMEM_MISALIGN_FAULT_EN
    task automatic test_split_read();
        run_req(0, 1'b1, 1'b0, 32'h06, 8'h0F, 64'h0, 0);
        n_tests++; if (obs_en_cnt !== 2 || obs_addr[0] !== 12'd0 || obs_addr[1] !== 12'd1) begin n_fail++; $display("FAIL split_beats: got %0d beats addr %h,%h expected 2 beats 000,001", obs_en_cnt, obs_addr[0], obs_addr[1]); end
        n_tests++; if (obs_ack_cnt !== 1 || obs_ack_cyc[0] !== 3) begin n_fail++; $display("FAIL split_ack: got %0d acks at %0d expected 1 at 3", obs_ack_cnt, obs_ack_cyc[0]); end
        n_tests++; if (obs_data !== 64'h0000000000FF8877) begin n_fail++; $display("FAIL split_data_r: got %h expected 0000000000ff8877", obs_data); end
    endtask

    task automatic test_wrap_write();
        run_req(1, 1'b0, 1'b1, 32'h1E, 8'h0F, 64'hDEADBEEF, 0);
        n_tests++; if (obs_en_cnt !== 2 || obs_addr[0] !== 12'd3 || obs_addr[1] !== 12'd0) begin n_fail++; $display("FAIL wrap_beats: got %0d beats addr %h,%h expected 2 beats 003,000", obs_en_cnt, obs_addr[0], obs_addr[1]); end
        n_tests++; if (obs_we[0] !== 8'hC0 || obs_we[1] !== 8'h03) begin n_fail++; $display("FAIL wrap_we: got %h,%h expected c0,03", obs_we[0], obs_we[1]); end
        n_tests++; if (obs_ack_cnt !== 1 || obs_ack_cyc[0] !== 3) begin n_fail++; $display("FAIL wrap_ack: got %0d acks at %0d expected 1 at 3", obs_ack_cnt, obs_ack_cyc[0]); end
        n_tests++; if (mem_b[3] !== 64'hBEEF000000000000) begin n_fail++; $display("FAIL wrap_mem3: got %h expected beef000000000000", mem_b[3]); end
        n_tests++; if (mem_b[0] !== 64'h000000000000DEAD) begin n_fail++; $display("FAIL wrap_mem0: got %h expected 000000000000dead", mem_b[0]); end
    endtask

    task automatic test_reset_mid_split();
        int acks;
        acks = 0;
        drive(0, 1'b1, 1'b0, 32'h06, 8'h0F, 64'h0);
        @(negedge clk);
        #1;
        if (bus_a.ack) acks++;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 8'h00, 64'h0);
        @(negedge clk);
        #1;
        if (bus_a.ack) acks++;
        n_tests++; if (a_en !== 1'b0 || a_we !== 8'h00 || a_addr !== 12'h0 || a_wdata !== 64'h0) begin n_fail++; $display("FAIL midrst_mem: got en %b we %h addr %h wdata %h expected all 0", a_en, a_we, a_addr, a_wdata); end
        n_tests++; if (bus_a.data_r !== 64'h0) begin n_fail++; $display("FAIL midrst_data_r: got %h expected 0", bus_a.data_r); end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            if (bus_a.ack) acks++;
        end
        n_tests++; if (acks !== 0) begin n_fail++; $display("FAIL midrst_no_ack: got %0d acks expected 0", acks); end
        @(negedge clk);
        run_req(0, 1'b1, 1'b0, 32'h20, 8'hFF, 64'h0, 0);
        n_tests++; if (obs_ack_cnt !== 1 || obs_data !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL midrst_recover: got %0d acks data %h expected 1 ack 0123456789abcdef", obs_ack_cnt, obs_data); end
    endtask
`else
    task automatic test_fault();
        run_req(0, 1'b1, 1'b0, 32'h07, 8'h03, 64'h0, 0);
        n_tests++; if (obs_en_cnt !== 0) begin n_fail++; $display("FAIL fault_mem_en: got %0d beats expected 0", obs_en_cnt); end
        n_tests++; if (obs_ack_cnt !== 1 || obs_ack_cyc[0] !== 2) begin n_fail++; $display("FAIL fault_ack: got %0d acks at %0d expected 1 at 2", obs_ack_cnt, obs_ack_cyc[0]); end
        n_tests++; if (obs_fault_at_ack !== 1'b1 || obs_fault_cnt !== 1) begin n_fail++; $display("FAIL fault_flag: got %b count %0d expected 1 count 1", obs_fault_at_ack, obs_fault_cnt); end
        n_tests++; if (obs_data !== 64'h0) begin n_fail++; $display("FAIL fault_data_r: got %h expected 0", obs_data); end
        run_req(1, 1'b0, 1'b1, 32'h1E, 8'h0F, 64'hDEADBEEF, 0);
        n_tests++; if (obs_en_cnt !== 0 || obs_fault_cnt !== 1) begin n_fail++; $display("FAIL fault_wrap: got %0d beats %0d faults expected 0 beats 1 fault", obs_en_cnt, obs_fault_cnt); end
        n_tests++; if (mem_b[3] !== 64'h0 || mem_b[0] !== 64'h0) begin n_fail++; $display("FAIL fault_wrap_mem: got %h,%h expected 0,0", mem_b[3], mem_b[0]); end
    endtask
`endif

    task automatic test_back_to_back();
        run_req(0, 1'b1, 1'b0, 32'h20, 8'hFF, 64'h0, 6);
        n_tests++; if (obs_ack_cnt !== 3) begin n_fail++; $display("FAIL b2b_ack_cnt: got %0d expected 3", obs_ack_cnt); end
        n_tests++; if (obs_ack_cyc[0] !== 2 || obs_ack_cyc[1] !== 5 || obs_ack_cyc[2] !== 8) begin n_fail++; $display("FAIL b2b_ack_cycles: got %0d,%0d,%0d expected 2,5,8", obs_ack_cyc[0], obs_ack_cyc[1], obs_ack_cyc[2]); end
        n_tests++; if (obs_en_cnt !== 3) begin n_fail++; $display("FAIL b2b_beats: got %0d expected 3", obs_en_cnt); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        pl_en = 1'b0; pl_unit = 1'b0; pl_addr = '0; pl_data = '0;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 8'h00, 64'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 8'h00, 64'h0);
        @(negedge clk);
        test_reset();
        preload(1'b0, 12'd4, 64'h0123456789ABCDEF);
        preload(1'b0, 12'd2, 64'h1122334455667788);
        preload(1'b0, 12'd0, 64'h8877665544332211);
        preload(1'b0, 12'd1, 64'h00000000000000FF);
        for (int i = 0; i < 4; i++) preload(1'b1, 12'(i), 64'h0);
        test_aligned_read();
        test_byte_write();
        test_zero_sel();
`ifndef DMEM_MISALIGN_FAULT_EN
        test_split_read();
        test_wrap_write();
        test_reset_mid_split();
`else
        test_fault();
`endif
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
